// File: rtl/imem_fetch_responder.sv
// imem_fetch_responder: req/ack instruction-fetch responder with wait states and a loader write port
module imem_fetch_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          req_i,
  input  logic [31:0]   addr_i,
  output logic          ack_o,
  output logic [31:0]   instr_o,
  output logic          err_o,
  output logic          busy_o,
  input  logic          ld_we_i,
  input  logic [AW-1:0] ld_addr_i,
  input  logic [31:0]   ld_data_i
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t        r_state;
  logic [3:0]    r_cnt;
  logic [AW-1:0] r_idx;
  logic [31:0]   r_instr;
  logic          r_err;
  logic [31:0]   r_mem [DEPTH_WORDS];
  logic          w_bad;
  logic [AW-1:0] w_idx;
  assign w_bad   = (addr_i[1:0] != 2'b00) || (addr_i[31:2] >= 30'(DEPTH_WORDS));
  assign w_idx   = addr_i[AW+1:2];
  assign ack_o   = (r_state == RESP);
  assign busy_o  = (r_state != IDLE);
  assign err_o   = r_err;
  assign instr_o = r_instr;
  // Separate write process keeps capture reads seeing the pre-edge word
  always_ff @(posedge clk_i)
    if (ld_we_i) r_mem[ld_addr_i] <= ld_data_i;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_instr <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (req_i) begin
          r_idx <= w_idx;
          if (w_bad) begin
            r_state <= RESP;
            r_err   <= 1'b1;
            r_instr <= '0;
          end else if (WAIT_CYCLES == 0) begin
            r_state <= RESP;
            r_instr <= r_mem[w_idx];
          end else begin
            r_cnt   <= 4'(WAIT_CYCLES - 1);
            r_state <= WAIT;
          end
        end
        WAIT: if (r_cnt == '0) begin
          r_state <= RESP;
          r_instr <= r_mem[r_idx];
        end else r_cnt <= r_cnt - 4'd1;
        RESP: begin
          r_state <= IDLE;
          r_err   <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_fetch_responder.sv
// tb_imem_fetch_responder: three responders (WAIT_CYCLES 2, 0, 4) on shared stimulus vs timestamp models
module tb_imem_fetch_responder;
  localparam int D = 256;
  logic clk = 0, rst = 1, req = 0, ld_we = 0;
  logic [31:0] addr = 0, ld_data = 0;
  logic [7:0] ld_addr = 0;
  logic ack [3];
  logic err [3];
  logic busy [3];
  logic [31:0] instr [3];
  logic [31:0] kw [4] = '{32'h0000_0013, 32'h0010_0093, 32'h0020_0113, 32'h2002_0005};
  int total = 0, bad = 0;
  bit chk = 0;
  always #5 clk = ~clk;
  task automatic cmp(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst%0d got=%h want=%h at %0t", nm, g, act, exp, $time);
    end
  endtask
  for (genvar g = 0; g < 3; g++) begin : gi
    localparam int W = (g == 0) ? 2 : (g == 1) ? 0 : 4;
    logic [31:0] m_arr [D];
    logic [31:0] e_instr = 0;
    bit e_ack = 0, e_err = 0, e_busy = 0, pend = 0, m_bad = 0;
    int n = 0, due = 0, m_wi = 0;
    imem_fetch_responder #(.DEPTH_WORDS(D), .WAIT_CYCLES(W)) dut (
      .clk_i(clk), .rst_i(rst), .req_i(req), .addr_i(addr),
      .ack_o(ack[g]), .instr_o(instr[g]), .err_o(err[g]), .busy_o(busy[g]),
      .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_data_i(ld_data));
    initial for (int i = 0; i < D; i++) m_arr[i] = 0;
    // Response is due W edges after the accepted request edge; bad addresses respond at once
    always @(posedge clk) begin
      n++;
      if (rst) begin
        pend = 0; e_ack = 0; e_err = 0; e_instr = 0;
      end else if (e_ack) begin
        e_ack = 0; e_err = 0;
      end else if (pend) begin
        if (n == due) begin pend = 0; e_ack = 1; e_instr = m_arr[m_wi]; end
      end else if (req) begin
        m_bad = (addr[1:0] != 0) || (addr[31:2] >= 30'(D));
        if (m_bad) begin
          e_ack = 1; e_err = 1; e_instr = 0;
        end else begin
          m_wi = int'(addr[31:2]);
          due = n + W;
          if (W == 0) begin e_ack = 1; e_instr = m_arr[m_wi]; end else pend = 1;
        end
      end
      e_busy = pend || e_ack;
      if (ld_we) m_arr[ld_addr] = ld_data;
    end
    always @(negedge clk) if (chk) begin
      cmp("ack", g, 32'(ack[g]), 32'(e_ack));
      cmp("err", g, 32'(err[g]), 32'(e_err));
      cmp("busy", g, 32'(busy[g]), 32'(e_busy));
      cmp("instr", g, instr[g], e_instr);
    end
  end
  task automatic idle(input int k);
    req = 0; ld_we = 0;
    repeat (k) @(negedge clk);
  endtask
  task automatic fetch(input int g, input logic [31:0] a, output logic [31:0] d);
    bit ok = 0;
    d = 0; req = 1; addr = a;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      req = 0;
      if (ack[g]) begin ok = 1; d = instr[g]; end
    end
    cmp("fetch_done", g, 32'(ok), 32'd1);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    logic [7:0] h0, h1, h2, hb;
    logic [31:0] d;
    bit any;
    rst = 1; req = 1; addr = 12;
    for (int i = 0; i < D; i++) begin
      @(negedge clk);
      chk = 1;
      if (i == 100) for (int g = 0; g < 3; g++) begin
        cmp("rst_ack", g, 32'(ack[g]), 0);
        cmp("rst_busy", g, 32'(busy[g]), 0);
        cmp("rst_instr", g, instr[g], 0);
      end
      ld_we = 1; ld_addr = 8'(i);
      ld_data = (i < 4) ? kw[i] : (i == 5) ? 32'hAAAA_AAAA : $urandom;
    end
    @(negedge clk);
    rst = 0; ld_we = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      h0[k] = ack[0]; h1[k] = ack[1]; h2[k] = ack[2]; hb[k] = busy[0];
      if (k == 0) cmp("w0_word", 1, instr[1], 32'h2002_0005);
      if (k == 2) begin
        cmp("basic_word", 0, instr[0], 32'h2002_0005);
        cmp("basic_err", 0, 32'(err[0]), 0);
      end
    end
    cmp("ack_pattern", 0, 32'(h0), 32'h44);
    cmp("ack_pattern", 1, 32'(h1), 32'h55);
    cmp("ack_pattern", 2, 32'(h2), 32'h10);
    cmp("busy_pattern", 0, 32'(hb), 32'h77);
    idle(12);
    for (int j = 0; j < 2; j++) begin
      req = 1; addr = (j == 0) ? 32'h6 : 32'(4 * D);
      @(negedge clk);
      req = 0;
      for (int g = 0; g < 3; g++) begin
        cmp("bad_ack", g, 32'(ack[g]), 1);
        cmp("bad_err", g, 32'(err[g]), 1);
        cmp("bad_instr", g, instr[g], 0);
      end
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
        cmp("bad_ack_drop", g, 32'(ack[g]), 0);
        cmp("bad_err_drop", g, 32'(err[g]), 0);
      end
      idle(2);
    end
    req = 1; addr = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k % 2 == 0) begin
        cmp("b2b_ack", 1, 32'(ack[1]), 1);
        cmp("b2b_word", 1, instr[1], kw[k / 2]);
        addr += 4;
      end else cmp("b2b_gap", 1, 32'(ack[1]), 0);
    end
    idle(12);
    req = 1; addr = 20;
    @(negedge clk);
    req = 0;
    @(negedge clk);
    ld_we = 1; ld_addr = 5; ld_data = 32'h5555_5555;
    @(negedge clk);
    ld_we = 0;
    cmp("coll_ack", 0, 32'(ack[0]), 1);
    cmp("coll_old", 0, instr[0], 32'hAAAA_AAAA);
    idle(12);
    fetch(0, 20, d);
    cmp("coll_new", 0, d, 32'h5555_5555);
    idle(12);
    req = 1; addr = 12;
    @(negedge clk);
    req = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    cmp("midrst_busy", 2, 32'(busy[2]), 0);
    cmp("midrst_instr", 2, instr[2], 0);
    any = 0;
    repeat (8) begin
      @(negedge clk);
      any |= ack[0] | ack[2];
    end
    cmp("midrst_noack", 2, 32'(any), 0);
    fetch(2, 12, d);
    cmp("midrst_refetch", 2, d, 32'h2002_0005);
    idle(12);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst = ($urandom_range(199) == 0);
      req = ($urandom_range(3) != 0);
      addr = ($urandom_range(9) == 0) ? $urandom : {22'h0, 8'($urandom), 2'b00};
      ld_we = ($urandom_range(3) == 0);
      ld_addr = 8'($urandom);
      ld_data = $urandom;
    end
    @(negedge clk);
    rst = 0;
    idle(20);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
